ram_bank: RTL and testbench



---
 rtl/ram_bank.sv | 109 ++++++++++
 tb/tb_ram_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ram_bank.sv
// Single-clock data memory: byte-masked write port, registered read port with
// write-first forwarding, and a clear engine that sweeps CLEAR_VALUE after reset or on request.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_CLEAR | sweeping CLEAR_VALUE into every word, port accesses ignored
// ST_IDLE  | normal operation, read and write ports serviced
module ram_bank #(
  parameter int                  DATA_WIDTH  = 16,
  parameter int                  ADDR_WIDTH  = 8,
  parameter int                  DEPTH       = 256,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Clear,
  output logic                    Busy,
  input  logic                    WE,
  input  logic [ADDR_WIDTH-1:0]   WriteAddress,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [DATA_WIDTH/8-1:0] ByteEnable,
  input  logic                    RE,
  input  logic [ADDR_WIDTH-1:0]   ReadAddress,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    ReadValid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    wr_in_range;
  logic                    rd_in_range;

  assign wr_in_range = ({1'b0, WriteAddress} < DEPTH_W);
  assign rd_in_range = ({1'b0, ReadAddress} < DEPTH_W);

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (cnt == LAST_ADDR) state_next = ST_IDLE;
      ST_IDLE:  if (Clear)            state_next = ST_CLEAR;
      default:                        state_next = ST_CLEAR;
    endcase
  end

  // Counter parks at 0 while idle so a Clear request always starts at word 0.
  always_ff @(posedge Clk) begin
    if (Reset)
      cnt <= '0;
    else if (state == ST_CLEAR && cnt != LAST_ADDR)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == ST_CLEAR) begin
        mem[cnt] <= CLEAR_VALUE;
      end else if (WE && wr_in_range) begin
        for (int i = 0; i < NB; i++)
          if (ByteEnable[i]) mem[WriteAddress][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  // Write-first: a same-cycle write to the read address is merged into the result.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[ReadAddress];
      if (WE && WriteAddress == ReadAddress)
        for (int i = 0; i < NB; i++)
          if (ByteEnable[i]) rd_word[8*i +: 8] = WriteData[8*i +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (state == ST_IDLE && RE) begin
      rd_data_q  <= rd_word;
      rd_valid_q <= 1'b1;
    end else begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end
  end

  assign Busy      = Reset || (state == ST_CLEAR);
  assign ReadData  = Reset ? '0 : rd_data_q;
  assign ReadValid = !Reset && rd_valid_q;

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: default 16x256 instance plus a 200-word
// instance with a non-zero clear value.
module tb_ram_bank;

  logic        Clk = 1'b0;
  logic        Reset, Clear, WE, RE;
  logic        Busy, ReadValid;
  logic [7:0]  WriteAddress, ReadAddress;
  logic [15:0] WriteData, ReadData;
  logic [1:0]  ByteEnable;

  logic        Reset2, Clear2, WE2, RE2;
  logic        Busy2, ReadValid2;
  logic [7:0]  WriteAddress2, ReadAddress2;
  logic [15:0] WriteData2, ReadData2;
  logic [1:0]  ByteEnable2;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles;

  always #5 Clk = ~Clk;

  ram_bank u_dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .Busy(Busy),
    .WE(WE), .WriteAddress(WriteAddress), .WriteData(WriteData), .ByteEnable(ByteEnable),
    .RE(RE), .ReadAddress(ReadAddress), .ReadData(ReadData), .ReadValid(ReadValid)
  );

  ram_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200), .CLEAR_VALUE(16'hA5A5)) u_dut2 (
    .Clk(Clk), .Reset(Reset2), .Clear(Clear2), .Busy(Busy2),
    .WE(WE2), .WriteAddress(WriteAddress2), .WriteData(WriteData2), .ByteEnable(ByteEnable2),
    .RE(RE2), .ReadAddress(ReadAddress2), .ReadData(ReadData2), .ReadValid(ReadValid2)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (Busy && cycles < 1000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic count_busy2(output int cycles);
    cycles = 0;
    while (Busy2 && cycles < 1000) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    Reset = 1; Clear = 0; WE = 0; RE = 0;
    WriteAddress = 0; ReadAddress = 0; WriteData = 0; ByteEnable = 0;
    Reset2 = 1; Clear2 = 0; WE2 = 0; RE2 = 0;
    WriteAddress2 = 0; ReadAddress2 = 0; WriteData2 = 0; ByteEnable2 = 0;

    // 1: reset then full sweep
    tick(); tick(); tick();
    chk("rst_busy", Busy, 1);
    chk("rst_valid", ReadValid, 0);
    chk("rst_data", ReadData, 0);
    Reset = 0;
    count_busy(busy_cycles);
    chk("sweep_len", busy_cycles, 256);
    RE = 1; ReadAddress = 8'h55;
    tick();
    RE = 0;
    chk("rd55_data", ReadData, 16'h0000);
    chk("rd55_valid", ReadValid, 1);

    // 2: full write, read, then idle read port
    WE = 1; WriteAddress = 9; WriteData = 16'hBEEF; ByteEnable = 2'b11;
    tick();
    WE = 0; RE = 1; ReadAddress = 9;
    tick();
    RE = 0;
    chk("rd9_data", ReadData, 16'hBEEF);
    chk("rd9_valid", ReadValid, 1);
    tick();
    chk("idle_data", ReadData, 16'h0000);
    chk("idle_valid", ReadValid, 0);

    // 3: byte masks
    WE = 1; WriteAddress = 10; WriteData = 16'h1234; ByteEnable = 2'b11;
    tick();
    WriteData = 16'hABCD; ByteEnable = 2'b01;
    tick();
    WE = 0; RE = 1; ReadAddress = 10;
    tick();
    RE = 0;
    chk("be01_data", ReadData, 16'h12CD);
    WE = 1; WriteData = 16'hABCD; ByteEnable = 2'b00;
    tick();
    WE = 0; RE = 1; ReadAddress = 10;
    tick();
    RE = 0;
    chk("be00_data", ReadData, 16'h12CD);

    // 4: write-first forwarding and independent ports
    WE = 1; WriteAddress = 11; WriteData = 16'h1111; ByteEnable = 2'b11;
    tick();
    WriteData = 16'h5A5A; ByteEnable = 2'b10; RE = 1; ReadAddress = 11;
    tick();
    chk("fwd_data", ReadData, 16'h5A11);
    chk("fwd_valid", ReadValid, 1);
    WriteAddress = 12; WriteData = 16'h9999; ByteEnable = 2'b11; ReadAddress = 11;
    tick();
    WE = 0;
    chk("indep_data", ReadData, 16'h5A11);
    ReadAddress = 12;
    tick();
    RE = 0;
    chk("rd12_data", ReadData, 16'h9999);

    // 5: clear request, ignored accesses, reset mid-sweep
    WE = 1; ByteEnable = 2'b11; WriteData = 16'hFFFF;
    for (int a = 0; a < 4; a++) begin
      WriteAddress = 8'(a);
      tick();
    end
    WE = 0;
    Clear = 1; RE = 1; ReadAddress = 9;
    tick();
    Clear = 0; RE = 0;
    chk("clr_busy", Busy, 1);
    chk("clr_rd_valid", ReadValid, 1);
    chk("clr_rd_data", ReadData, 16'hBEEF);
    WE = 1; WriteAddress = 0; WriteData = 16'h1234; RE = 1; ReadAddress = 1;
    tick();
    WE = 0; RE = 0;
    chk("busy_rd_valid", ReadValid, 0);
    chk("busy_rd_data", ReadData, 0);
    for (int i = 0; i < 98; i++) tick();
    chk("mid_busy", Busy, 1);
    Reset = 1;
    tick();
    Reset = 0;
    count_busy(busy_cycles);
    chk("resweep_len", busy_cycles, 256);
    RE = 1;
    for (int a = 0; a < 4; a++) begin
      ReadAddress = 8'(a);
      tick();
      chk($sformatf("clr_rd%0d", a), ReadData, 16'h0000);
      chk($sformatf("clr_v%0d", a), ReadValid, 1);
    end
    RE = 0;

    // 6: DEPTH=200, CLEAR_VALUE=A5A5
    Reset2 = 0;
    count_busy2(busy_cycles);
    chk("d200_sweep", busy_cycles, 200);
    RE2 = 1; ReadAddress2 = 5;
    tick();
    chk("d200_rd5", ReadData2, 16'hA5A5);
    ReadAddress2 = 199;
    tick();
    RE2 = 0;
    chk("d200_rd199", ReadData2, 16'hA5A5);
    WE2 = 1; WriteAddress2 = 250; WriteData2 = 16'h7777; ByteEnable2 = 2'b11;
    tick();
    WE2 = 0; RE2 = 1; ReadAddress2 = 250;
    tick();
    RE2 = 0;
    chk("oor_data", ReadData2, 16'h0000);
    chk("oor_valid", ReadValid2, 1);
    WE2 = 1; WriteAddress2 = 199; WriteData2 = 16'h0102; ByteEnable2 = 2'b01;
    tick();
    WE2 = 0; RE2 = 1; ReadAddress2 = 199;
    tick();
    RE2 = 0;
    chk("d200_be199", ReadData2, 16'hA502);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
